// File: rtl/precision_dac_ctrl_pkg.sv
// Shared definitions for the precision DAC serial controller.
// Holds the frame geometry, the sequencer state type and the helper that
// assembles one 24-bit DAC frame from a command nibble, a channel index
// and a 16-bit channel word.
package precision_dac_ctrl_pkg;

  localparam int FRAME_W = 24;
  localparam int NUM_CH  = 4;
  localparam int WORD_W  = 16;
  localparam int CMD_W   = 4;
  localparam int ADDR_W  = 4;
  localparam int CH_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    LDAC
  } dacState_e;

  // The address field is one-hot: channel 0 -> 0001 ... channel 3 -> 1000.
  function automatic logic [FRAME_W-1:0] buildFrame(
    input logic [CMD_W-1:0]  cmd,
    input logic [CH_W-1:0]   chan,
    input logic [WORD_W-1:0] word
  );
    logic [ADDR_W-1:0] addr;
    addr = ADDR_W'(1) << chan;
    return {cmd, addr, word};
  endfunction

endpackage

// File: rtl/precision_dac_spi_shifter.sv
// Serialises one 24-bit DAC frame, MSB first.
// Ports:
//   clk_i, rst_i     system clock, asynchronous active-high reset
//   start_i          one-cycle request; frame_i is captured on that edge
//   frame_i[23:0]    frame to send
//   sync_o           active-low frame select (registered)
//   sclk_o           serial clock, idles high (registered)
//   sdi_o            serial data, 0 outside a frame (registered)
//   lastCycle_o      high in the final cycle of a frame, so the caller can
//                    change state on the same edge that releases sync
// Each bit spends SCLK_HALF cycles with sclk high, then SCLK_HALF low. sdi
// only moves together with a rising sclk, so it is stable at the falling
// edge where the DAC samples it.
module precision_dac_spi_shifter
  import precision_dac_ctrl_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               sync_o,
  output logic               sclk_o,
  output logic               sdi_o,
  output logic               lastCycle_o
);

  localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);
  localparam logic [4:0] BIT_LAST  = 5'(FRAME_W - 1);

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [7:0]         halfCnt_q, halfCnt_d;
  logic [4:0]         bitCnt_q, bitCnt_d;
  logic               phaseLow_q, phaseLow_d;
  logic               busy_q, busy_d;
  logic               sync_q, sync_d;
  logic               sclk_q, sclk_d;
  logic               sdi_q, sdi_d;
  logic               halfEnd;

  assign halfEnd     = (halfCnt_q == HALF_LAST);
  assign lastCycle_o = busy_q & phaseLow_q & halfEnd & (bitCnt_q == BIT_LAST);

  // Next-state: a load restarts everything; otherwise walk high/low halves
  // and advance to the next bit at the end of each low half.
  always_comb begin
    shift_d    = shift_q;
    halfCnt_d  = halfCnt_q;
    bitCnt_d   = bitCnt_q;
    phaseLow_d = phaseLow_q;
    busy_d     = busy_q;
    sync_d     = sync_q;
    sclk_d     = sclk_q;
    sdi_d      = sdi_q;
    if (start_i) begin
      shift_d    = frame_i;
      halfCnt_d  = '0;
      bitCnt_d   = '0;
      phaseLow_d = 1'b0;
      busy_d     = 1'b1;
      sync_d     = 1'b0;
      sclk_d     = 1'b1;
      sdi_d      = frame_i[FRAME_W-1];
    end else if (busy_q) begin
      if (!halfEnd) begin
        halfCnt_d = halfCnt_q + 8'd1;
      end else begin
        halfCnt_d = '0;
        if (!phaseLow_q) begin
          phaseLow_d = 1'b1;
          sclk_d     = 1'b0;
        end else if (bitCnt_q == BIT_LAST) begin
          // Frame complete: sync and sclk rise together.
          phaseLow_d = 1'b0;
          busy_d     = 1'b0;
          sync_d     = 1'b1;
          sclk_d     = 1'b1;
          sdi_d      = 1'b0;
        end else begin
          phaseLow_d = 1'b0;
          bitCnt_d   = bitCnt_q + 5'd1;
          shift_d    = shift_q << 1;
          sclk_d     = 1'b1;
          sdi_d      = shift_q[FRAME_W-2];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q    <= '0;
      halfCnt_q  <= '0;
      bitCnt_q   <= '0;
      phaseLow_q <= 1'b0;
      busy_q     <= 1'b0;
      sync_q     <= 1'b1;
      sclk_q     <= 1'b1;
      sdi_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      halfCnt_q  <= halfCnt_d;
      bitCnt_q   <= bitCnt_d;
      phaseLow_q <= phaseLow_d;
      busy_q     <= busy_d;
      sync_q     <= sync_d;
      sclk_q     <= sclk_d;
      sdi_q      <= sdi_d;
    end
  end

  assign sync_o = sync_q;
  assign sclk_o = sclk_q;
  assign sdi_o  = sdi_q;

endmodule

// File: rtl/precision_dac_ctrl.sv
// Refresh sequencer for a 4-channel 16-bit serial DAC.
// Ports:
//   clk_i, rst_i   system clock, asynchronous active-high reset
//   data_i[63:0]   channel words, channel i in data_i[16*i +: 16]
//   valid_i        level enable; while high, sweeps repeat back to back
//   cmd_i[3:0]     command nibble placed in every frame
//   sync_o         active-low frame select
//   sclk_o         serial clock, idles high
//   sdi_o          serial data, MSB first
//   ldac_o         active-low load strobe, idles high
// A sweep is four frames (ch0..ch3), each followed by SYNC_GAP cycles of
// sync high, then an LDAC_PULSE-cycle ldac low pulse. valid_i is only
// consulted in IDLE and at the end of the ldac pulse, so a sweep that has
// started always runs to completion.
module precision_dac_ctrl
  import precision_dac_ctrl_pkg::*;
#(
  parameter int SCLK_HALF  = 2,
  parameter int SYNC_GAP   = 4,
  parameter int LDAC_PULSE = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH*WORD_W-1:0] data_i,
  input  logic                     valid_i,
  input  logic [CMD_W-1:0]         cmd_i,
  output logic                     sync_o,
  output logic                     sclk_o,
  output logic                     sdi_o,
  output logic                     ldac_o
);

  localparam logic [7:0]      GAP_LAST  = 8'(SYNC_GAP - 1);
  localparam logic [7:0]      LDAC_LAST = 8'(LDAC_PULSE - 1);
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);

  dacState_e          state_q, state_d;
  logic [CH_W-1:0]    channel_q, channel_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ldac_q, ldac_d;
  logic               shiftStart;
  logic               shiftLast;
  logic [FRAME_W-1:0] shiftFrame;

  // Sequencer. A frame start is requested combinationally on the edge that
  // enters SHIFT, so sync falls on that same edge and the gap stays exact.
  always_comb begin
    state_d    = state_q;
    channel_d  = channel_q;
    cnt_d      = cnt_q;
    shiftStart = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d    = SHIFT;
          channel_d  = '0;
          shiftStart = 1'b1;
        end
      end
      SHIFT: begin
        if (shiftLast) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (channel_q != CH_LAST) begin
            state_d    = SHIFT;
            channel_d  = channel_q + CH_W'(1);
            shiftStart = 1'b1;
          end else begin
            state_d = LDAC;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LDAC: begin
        if (cnt_q == LDAC_LAST) begin
          cnt_d = '0;
          if (valid_i) begin
            state_d    = SHIFT;
            channel_d  = '0;
            shiftStart = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ldac is registered from the next state so it is low exactly while the
  // sequencer sits in LDAC.
  assign ldac_d = (state_d != LDAC);

  // The frame is built from the channel about to be sent and is captured by
  // the shifter at start, so later input changes cannot disturb it.
  assign shiftFrame = buildFrame(cmd_i, channel_d, data_i[WORD_W*channel_d +: WORD_W]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      channel_q <= '0;
      cnt_q     <= '0;
      ldac_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      channel_q <= channel_d;
      cnt_q     <= cnt_d;
      ldac_q    <= ldac_d;
    end
  end

  precision_dac_spi_shifter #(
    .SCLK_HALF (SCLK_HALF)
  ) u_shifter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (shiftStart),
    .frame_i     (shiftFrame),
    .sync_o      (sync_o),
    .sclk_o      (sclk_o),
    .sdi_o       (sdi_o),
    .lastCycle_o (shiftLast)
  );

  assign ldac_o = ldac_q;

endmodule

// File: tb/tb_precision_dac_ctrl.sv
// Scoreboard bench for precision_dac_ctrl. A timing-level model predicts
// every frame (value and start cycle) and every ldac pulse; a monitor
// decodes the pins and compares against those predictions.
module tb_precision_dac_ctrl;

  localparam int SCLK_HALF  = 2;
  localparam int SYNC_GAP   = 4;
  localparam int LDAC_PULSE = 4;
  localparam int FRAME_CYC  = 24 * 2 * SCLK_HALF;

  localparam logic [63:0] BASIC_DATA   = 64'hE801_EC01_EC01_EC01;
  localparam logic [63:0] UPDATED_DATA = 64'hEC01_EC01_EC01_E801;

  typedef struct {
    logic [23:0] frame;
    int unsigned start;
  } expFrame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data;
  logic        valid;
  logic [3:0]  cmd;
  logic        sync, sclk, sdi, ldac;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  expFrame_t   frameQ[$];
  int unsigned ldacQ[$];
  event        modelGo;
  bit          modelIdle = 1'b1;
  int          modelCh = 0;

  bit          monEn = 1'b0;
  logic        pSync, pSclk, pSdi, pLdac;
  int unsigned fStart, fLastFall, lStart;
  logic [23:0] fBits;
  int          nBits, fViol;
  int          protoViol = 0;
  int          framesSeen = 0;
  int          ldacSeen = 0;

  precision_dac_ctrl #(
    .SCLK_HALF  (SCLK_HALF),
    .SYNC_GAP   (SYNC_GAP),
    .LDAC_PULSE (LDAC_PULSE)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (data),
    .valid_i (valid),
    .cmd_i   (cmd),
    .sync_o  (sync),
    .sclk_o  (sclk),
    .sdi_o   (sdi),
    .ldac_o  (ldac)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [63:0] d);
    @(negedge clk);
    valid = v;
    cmd   = c;
    data  = d;
  endtask

  // Frame = cmd * 2^20 + (one-hot channel) * 2^16 + word.
  function automatic logic [23:0] refFrame(input logic [3:0] c, input int ch, input logic [63:0] d);
    logic [63:0] sh;
    int unsigned word, addr, total;
    sh    = d >> (16 * ch);
    word  = 32'(sh[15:0]);
    addr  = 32'd1 << ch;
    total = 32'(c) * 32'h10_0000 + addr * 32'h1_0000 + word;
    return total[23:0];
  endfunction

  // Behavioural model: each frame occupies FRAME_CYC + SYNC_GAP cycles from
  // its start edge, a sweep ends with an LDAC_PULSE wait, and valid is only
  // looked at while idle or when the pulse ends. Inputs are sampled on the
  // frame start edge. Start cycles are cyc+1 because cyc advances on that edge.
  initial begin
    expFrame_t e;
    @(modelGo);
    forever begin
      modelIdle = 1'b1;
      do @(posedge clk); while (!valid);
      modelIdle = 1'b0;
      do begin
        for (int ch = 0; ch < 4; ch++) begin
          modelCh = ch;
          e.frame = refFrame(cmd, ch, data);
          e.start = cyc + 1;
          frameQ.push_back(e);
          repeat (FRAME_CYC + SYNC_GAP) @(posedge clk);
        end
        ldacQ.push_back(cyc + 1);
        repeat (LDAC_PULSE) @(posedge clk);
      end while (valid);
    end
  end

  // Monitor: decodes frames from sclk falling edges and checks protocol.
  always @(negedge clk) begin
    if (monEn) begin
      if (pSync && !sync) begin
        fStart = cyc;
        fBits  = '0;
        nBits  = 0;
        fViol  = 0;
      end
      if (!sync) begin
        if (pSclk && !sclk) begin
          if (nBits > 0 && (cyc - fLastFall) != 2 * SCLK_HALF) fViol++;
          if (sdi !== pSdi) fViol++;
          fBits     = {fBits[22:0], sdi};
          nBits     = nBits + 1;
          fLastFall = cyc;
        end
      end else begin
        if (sdi !== 1'b0) protoViol++;
        if (sclk !== 1'b1) protoViol++;
      end
      if (!ldac && !sync) protoViol++;
      if (!pSync && sync) begin
        framesSeen++;
        if (frameQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_frame: got %06h expected none", fBits);
        end else begin
          expFrame_t e;
          e = frameQ.pop_front();
          checkOutput("frame_data", 32'(fBits), 32'(e.frame));
          checkOutput("frame_start", fStart, e.start);
          checkOutput("sync_low_len", cyc - fStart, FRAME_CYC);
          checkOutput("frame_bits", nBits, 24);
          checkOutput("frame_timing", fViol, 0);
        end
      end
      if (pLdac && !ldac) begin
        lStart = cyc;
        if (ldacQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_ldac: got pulse at %0d expected none", cyc);
        end else begin
          checkOutput("ldac_start", cyc, ldacQ.pop_front());
        end
      end
      if (!pLdac && ldac) begin
        ldacSeen++;
        checkOutput("ldac_len", cyc - lStart, LDAC_PULSE);
      end
      pSync = sync;
      pSclk = sclk;
      pSdi  = sdi;
      pLdac = ldac;
    end
  end

  initial begin
    int act;
    bit done;
    rst   = 1'b1;
    valid = 1'b0;
    cmd   = 4'h0;
    data  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sync", 32'(sync), 1);
    checkOutput("reset_sclk", 32'(sclk), 1);
    checkOutput("reset_sdi", 32'(sdi), 0);
    checkOutput("reset_ldac", 32'(ldac), 1);
    rst = 1'b0;

    act = 0;
    repeat (100) begin
      @(negedge clk);
      if (!sync || !sclk || sdi || !ldac) act++;
    end
    checkOutput("idle_quiet", act, 0);

    // Asynchronous reset in the middle of the second frame.
    applyStimulus(1'b1, 4'b0001, BASIC_DATA);
    repeat (150) @(negedge clk);
    checkOutput("pre_reset_sync", 32'(sync), 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_sync", 32'(sync), 1);
    checkOutput("async_rst_sclk", 32'(sclk), 1);
    checkOutput("async_rst_sdi", 32'(sdi), 0);
    checkOutput("async_rst_ldac", 32'(ldac), 1);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    repeat (100) begin
      @(negedge clk);
      if (!sync || !sclk || sdi || !ldac) act++;
    end
    checkOutput("post_reset_quiet", act, 0);

    // Scoreboard phase.
    pSync = 1'b1;
    pSclk = 1'b1;
    pSdi  = 1'b0;
    pLdac = 1'b1;
    monEn = 1'b1;
    ->modelGo;
    applyStimulus(1'b1, 4'b0001, BASIC_DATA);
    repeat (2000) @(negedge clk);
    applyStimulus(1'b1, 4'b0001, UPDATED_DATA);
    repeat (1000) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(30, 500)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        valid = 1'b0;
        repeat ($urandom_range(1, 30)) @(negedge clk);
        valid = 1'b1;
      end else begin
        cmd  = 4'($urandom);
        data = {$urandom, $urandom};
      end
    end

    // Drop valid during the second frame of a sweep.
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (!modelIdle && modelCh == 1) done = 1'b1;
    end
    checkOutput("reach_frame2", 32'(done), 1);
    valid = 1'b0;

    done = 1'b0;
    for (int i = 0; i < 1500 && !done; i++) begin
      @(negedge clk);
      if (modelIdle && frameQ.size() == 0 && ldacQ.size() == 0) done = 1'b1;
    end
    checkOutput("drain", 32'(done), 1);

    act = 0;
    repeat (200) begin
      @(negedge clk);
      if (!sync || !sclk || sdi || !ldac) act++;
    end
    checkOutput("final_quiet", act, 0);
    checkOutput("protocol_violations", protoViol, 0);
    checkOutput("ldac_per_4_frames", framesSeen, 4 * ldacSeen);
    checkOutput("frames_pending", frameQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/precision_dac_ctrl.md
Name: precision_dac_ctrl

Overview:
- Serial controller for a 4-channel, 16-bit precision DAC (AD5686-class) using a 24-bit SPI-style frame with SYNC, SCLK, SDI and LDAC.
- While `valid` is high it refreshes all four channels continuously, one frame per channel, then pulses LDAC so all outputs update together.
- Sits between the host register bank (data/cmd/valid) and the board DAC pins.

Parameters:
- SCLK_HALF, 2, clk cycles per SCLK half-period (SCLK = clk/4 = 31.25 MHz at 125 MHz).
- SYNC_GAP, 4, clk cycles SYNC is held high between frames.
- LDAC_PULSE, 4, clk cycles LDAC is held low after the 4th frame of a sweep.

Ports:
- clk, in, 1, system clock (125 MHz nominal).
- rst, in, 1, asynchronous active-high reset.
- data, in, 64, channel words; channel i = data[16*i+15 : 16*i].
- valid, in, 1, level enable; high = keep refreshing.
- cmd, in, 4, DAC command nibble placed in every frame (e.g. 4'b0001).
- sync, out, 1, active-low frame select.
- sclk, out, 1, serial clock, idles high.
- sdi, out, 1, serial data, MSB first.
- ldac, out, 1, active-low load DAC, idles high.

Behaviour:
- Reset (asynchronous, any state): sync=1, sclk=1, sdi=0, ldac=1, state=IDLE, channel index=0. All outputs are registered.
- Frame for channel i = {cmd[3:0], addr[3:0], word[15:0]}, 24 bits.
  - addr = one-hot (1<<i): ch0=0001, ch1=0010, ch2=0100, ch3=1000.
  - The frame is latched from data/cmd when the frame starts; input changes mid-frame do not affect it.
- State IDLE:
  - Outputs at idle levels.
  - If valid=1, the next cycle enters SHIFT with channel 0.
- State SHIFT:
  - sync=0, and sdi=bit 23 in the first cycle; sclk is high.
  - Each bit lasts 2*SCLK_HALF clk cycles: sclk high for SCLK_HALF, then low for SCLK_HALF.
  - The DAC samples sdi on the sclk falling edge. sdi changes only together with an sclk rising edge, so it is stable across the falling edge.
  - After the 24th low half, sclk returns high and sync returns high together.
  - sync is low for exactly 24*2*SCLK_HALF = 96 cycles at default parameters.
- State GAP:
  - sync=1, sclk=1 for SYNC_GAP cycles.
  - If channel < 3: increment the channel and go to SHIFT.
  - Else: go to LDAC.
- State LDAC:
  - ldac=0 for LDAC_PULSE cycles, then ldac=1.
  - If valid=1: channel=0, go to SHIFT. Else go to IDLE.
- Sweep length at default parameters: 4*(96+4)+4 = 404 cycles.
- valid falling mid-sweep: the current sweep completes, including the LDAC pulse, then returns to IDLE. No truncated frames are ever emitted.
- valid rising while not in IDLE has no effect.
- Frame ordering is always ch0, ch1, ch2, ch3. LDAC never overlaps sync=0.
- sdi=0 whenever sync=1.

Decomposition:
- Shared package:
  - Frame width 24, channel count 4, word width 16.
  - State enum {IDLE, SHIFT, GAP, LDAC}.
  - Function building the 24-bit frame from (cmd, channel, word).
- One natural sub-module, precision_dac_spi_shifter:
  - Loads 24 bits, generates sclk/sdi/sync, and signals done.
  - The top-level sequences channels and LDAC.

Test Plan:
- Reset: assert rst mid-frame -> sync=1, sclk=1, sdi=0, ldac=1 immediately (asynchronously); no activity while valid=0 for 100 cycles.
- Basic sweep: cmd=0001, data={E801, EC01, EC01, EC01} (ch3 in the MSBs), valid=1.
  - Serial frames, sampled on sclk falling edges, equal 0x11EC01, 0x12EC01, 0x14EC01, 0x18E801.
  - One ldac low pulse of 4 cycles follows the 4th frame.
- Timing check:
  - sync low exactly 96 cycles per frame; 4-cycle gaps; sweep period 404 cycles.
  - sclk period 4 cycles; sdi never toggles at a falling sclk edge.
- Data update: after ~2000 cycles change data to {EC01, EC01, EC01, E801}.
  - The next full sweep shows ch0 frame 0x11E801 and ch3 frame 0x18EC01.
  - A frame already in progress keeps its latched value.
- valid drop: deassert valid during the 2nd frame -> frames 3 and 4 plus the LDAC pulse still occur, then return to idle with no further sync activity.
- Continuous run for 100000 cycles -> back-to-back sweeps, exactly one LDAC pulse per 4 frames, no protocol violations.
